cpu_control_fsm: RTL and testbench
==================================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter: CNT_W, 32, width of the performance counters.
REQ-002 Port: clk  input  1  system clock; the state register updates on the rising edge, so all outputs are stable before the datapath's falling-edge writes.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: run  input  1  1 = execute instructions; 0 = park in IDLE at the next instruction boundary.
REQ-005 Port: IR  input  32  latched instruction from the fetch stage.
REQ-006 Port: W_IR_valid  input  1  condition-pass flag for the instruction currently on the ROM output.
REQ-007 Port: write_pc  output  1  PC += 4 strobe.
REQ-008 Port: write_ir  output  1  IR load strobe.
REQ-009 Port: write_a, write_b  output  1 each  operand register load strobes.
REQ-010 Port: write_c  output  1  ALU result register load strobe.
REQ-011 Port: write_nzcv  output  1  flag register update strobe.
REQ-012 Port: write_reg  output  1  register file write-back strobe.
REQ-013 Port: alu_op  output  4  ALU opcode.
REQ-014 Port: b_imm  output  1  1 = ALU B operand is the immediate.
REQ-015 Port: illegal  output  1  one-cycle pulse on an unsupported instruction class.
REQ-016 Port: state  output  3  current state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4.
REQ-017 Port: cycle_cnt, instr_cnt  output  CNT_W each  performance counters.

Function
REQ-018 The block SHALL be a Moore FSM with states IDLE, FETCH, DECODE, EXEC and WB; every strobe SHALL be a decode of state and IR only, never of run or W_IR_valid.
REQ-019 IDLE: all strobes 0; go to FETCH when run=1, otherwise stay in IDLE.
REQ-020 FETCH: write_pc=1 and write_ir=1.
- W_IR_valid=0 (condition failed): the instruction is skipped; go to FETCH if run=1, else IDLE.
- W_IR_valid=1: go to DECODE.
REQ-021 DECODE: write_a=1 and write_b=1.
- IR[27:26]!=2'b00: illegal=1 for this cycle, then go to FETCH (IDLE if run=0).
- Otherwise: go to EXEC.
REQ-022 EXEC: write_c=1, alu_op=IR[24:21], b_imm=IR[25].
- write_nzcv=IR[20], forced to 1 when alu_op is 4'h8-4'hB (compare class).
REQ-023 EXEC exit:
- Compare class (4'h8-4'hB) has no write-back: go to FETCH (IDLE if run=0).
- Otherwise: go to WB.
REQ-024 WB: write_reg=1, then go to FETCH if run=1, else IDLE.
REQ-025 Outside EXEC, alu_op and b_imm SHALL be 0.
REQ-026 Latency: a written-back instruction takes 4 cycles (FETCH-DECODE-EXEC-WB), a compare takes 3, a condition-failed instruction takes 1.
REQ-027 run deasserted mid-instruction SHALL NOT abort the instruction; it takes effect only at the FETCH, DECODE-illegal, EXEC-compare or WB exits.
REQ-028 Unused state encodings (5-7) SHALL return to IDLE on the next clock, with all strobes 0.

Reset
REQ-029 rst=1 SHALL force state to IDLE, all strobes and illegal to 0, and both counters to 0, immediately and independently of clk.
REQ-030 Reset asserted mid-instruction SHALL discard that instruction; after release, the first FETCH requires run=1.

Configuration
REQ-031 The macro CTRL_PERF_CNT_EN, when defined, SHALL enable two counters, each wrapping modulo 2^CNT_W:
- cycle_cnt: +1 every clock with state!=IDLE.
- instr_cnt: +1 on every WB exit and every EXEC-compare exit.
REQ-032 Without CTRL_PERF_CNT_EN, cycle_cnt and instr_cnt SHALL remain present and be tied to 0, and no counter flops SHALL be generated.

Verification
REQ-033 Reset, run=1, IR=32'hE0812003 (ADD, W_IR_valid=1) -> strobes follow FETCH, DECODE, EXEC (alu_op=4'h4, write_nzcv=0), WB; instr_cnt=1 and cycle_cnt=4 (macro on).
REQ-034 IR=32'hE3500000 (CMP imm) -> EXEC has alu_op=4'hA, b_imm=1, write_nzcv=1; no WB cycle; next state is FETCH.
REQ-035 W_IR_valid=0 during FETCH -> next state FETCH, write_pc=1 on each such cycle, instr_cnt unchanged.
REQ-036 IR=32'hEA000000 (branch class) -> illegal=1 for exactly one DECODE cycle, then FETCH, no write_c.
REQ-037 rst pulsed during EXEC -> state=0 and all strobes 0 without waiting for a clock edge; with run=0 after release, the FSM stays in IDLE.
REQ-038 run dropped during DECODE of an ADD -> EXEC and WB complete, then IDLE; cycle_cnt stops incrementing.

Source files
------------

// File: rtl/cpu_control_fsm.sv
// cpu_control_fsm -- Moore control FSM for a multi-cycle ARM-like datapath.
//
// Instruction flow: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ...
//   - FETCH with a failed condition (W_IR_valid=0) skips the instruction.
//   - DECODE of an unsupported class (IR[27:26]!=0) pulses illegal.
//   - EXEC of a compare (alu_op 8..B) updates flags only and skips WB.
//   - run is sampled only at instruction boundaries, so an instruction
//     already in flight always completes.
//
// Every strobe is decoded from the state register and IR only. The state
// register updates on the rising edge, so the strobes are settled well
// before the datapath's falling-edge writes.
//
// Optional build macro:
//   CTRL_PERF_CNT_EN -- enables the cycle_cnt / instr_cnt performance
//                       counters. When undefined the ports stay present
//                       and are tied to zero, and no counter flops exist.
//
// Ports:
//   clk         in   system clock (rising edge)
//   rst         in   asynchronous active-high reset
//   run         in   1 = keep executing, 0 = park in IDLE at next boundary
//   IR          in   [31:0] latched instruction
//   W_IR_valid  in   condition-pass flag for the fetched instruction
//   write_pc    out  PC += 4 strobe
//   write_ir    out  IR load strobe
//   write_a/b   out  operand register load strobes
//   write_c     out  ALU result register load strobe
//   write_nzcv  out  flag register update strobe
//   write_reg   out  register file write-back strobe
//   alu_op      out  [3:0] ALU opcode (0 outside EXEC)
//   b_imm       out  ALU B operand select: 1 = immediate (0 outside EXEC)
//   illegal     out  one-cycle pulse on an unsupported instruction class
//   state       out  [2:0] IDLE=0 FETCH=1 DECODE=2 EXEC=3 WB=4
//   cycle_cnt   out  [CNT_W-1:0] non-idle clock count
//   instr_cnt   out  [CNT_W-1:0] retired instruction count
module cpu_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      IR,
  input  logic             W_IR_valid,
  output logic             write_pc,
  output logic             write_ir,
  output logic             write_a,
  output logic             write_b,
  output logic             write_c,
  output logic             write_nzcv,
  output logic             write_reg,
  output logic [3:0]       alu_op,
  output logic             b_imm,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4
  } st_e;

  st_e st_q, st_d;

  // Instruction fields used by the decode.
  logic [3:0] ir_op;
  logic       ir_imm;
  logic       ir_s;
  logic       ir_bad_class;
  logic       ir_cmp;

  assign ir_op        = IR[24:21];
  assign ir_imm       = IR[25];
  assign ir_s         = IR[20];
  assign ir_bad_class = (IR[27:26] != 2'b00);
  // Compare class is opcodes 8..B, i.e. top two opcode bits == 2'b10.
  assign ir_cmp       = (ir_op[3:2] == 2'b10);

  // Condition code, link/offset fields etc. are not used by the control.
  logic unused_ir;
  assign unused_ir = ^{IR[31:28], IR[19:0]};

  // Exit target shared by every instruction boundary.
  st_e boundary_nxt;
  assign boundary_nxt = run ? S_FETCH : S_IDLE;

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= S_IDLE;
    else     st_q <= st_d;
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    st_d = S_IDLE;
    case (st_q)
      S_IDLE:   st_d = run ? S_FETCH : S_IDLE;
      S_FETCH:  st_d = W_IR_valid ? S_DECODE : boundary_nxt;
      S_DECODE: st_d = ir_bad_class ? boundary_nxt : S_EXEC;
      S_EXEC:   st_d = ir_cmp ? boundary_nxt : S_WB;
      S_WB:     st_d = boundary_nxt;
      default:  st_d = S_IDLE;  // unused encodings recover to IDLE
    endcase
  end

  // ------------------------------------------------------------------
  // Output decode (state + IR only)
  // ------------------------------------------------------------------
  always_comb begin
    write_pc   = 1'b0;
    write_ir   = 1'b0;
    write_a    = 1'b0;
    write_b    = 1'b0;
    write_c    = 1'b0;
    write_nzcv = 1'b0;
    write_reg  = 1'b0;
    alu_op     = 4'h0;
    b_imm      = 1'b0;
    illegal    = 1'b0;
    case (st_q)
      S_FETCH: begin
        write_pc = 1'b1;
        write_ir = 1'b1;
      end
      S_DECODE: begin
        write_a = 1'b1;
        write_b = 1'b1;
        illegal = ir_bad_class;
      end
      S_EXEC: begin
        write_c    = 1'b1;
        alu_op     = ir_op;
        b_imm      = ir_imm;
        // Compares exist only to set flags, so force the update.
        write_nzcv = ir_s | ir_cmp;
      end
      S_WB: write_reg = 1'b1;
      default: ;
    endcase
  end

  assign state = st_q;

  // ------------------------------------------------------------------
  // Performance counters
  // ------------------------------------------------------------------
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ins_q;
  logic             retire;

  // An instruction retires when it leaves WB or leaves EXEC as a compare.
  assign retire = (st_q == S_WB) || ((st_q == S_EXEC) && ir_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      if (st_q != S_IDLE) cyc_q <= cyc_q + CNT_W'(1);
      if (retire)         ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_cnt = cyc_q;
  assign instr_cnt = ins_q;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm. The driver steps one clock at a
// time, plans each instruction as a list of phases from its IR class and
// condition flag, and queues the expected outputs of every cycle; a
// separate monitor pops and compares them on the falling edge.
module tb_cpu_control_fsm;
  localparam int CNT_W = 32;
  localparam int P_I = 0, P_F = 1, P_D = 2, P_E = 3, P_W = 4;
`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             run = 1'b0;
  logic [31:0]      IR = 32'h0;
  logic             W_IR_valid = 1'b0;
  logic             write_pc, write_ir, write_a, write_b, write_c;
  logic             write_nzcv, write_reg, b_imm, illegal;
  logic [3:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  cpu_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run(run), .IR(IR), .W_IR_valid(W_IR_valid),
    .write_pc(write_pc), .write_ir(write_ir), .write_a(write_a),
    .write_b(write_b), .write_c(write_c), .write_nzcv(write_nzcv),
    .write_reg(write_reg), .alu_op(alu_op), .b_imm(b_imm),
    .illegal(illegal), .state(state),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic pc, wir, a, b, c, nzcv, wreg, ill;
    logic [3:0] op;
    logic bimm;
  } outv_t;

  typedef struct packed {
    outv_t            o;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] ins;
  } sb_t;

  sb_t sbq[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  // Reference model state: current instruction as a list of phases.
  bit               m_busy = 1'b0;
  bit               start_next = 1'b0;
  int               plan[$];
  int               idx = 0;
  logic [31:0]      m_ir = 32'h0;
  logic             m_val = 1'b0;
  logic [CNT_W-1:0] m_cyc = '0;
  logic [CNT_W-1:0] m_ins = '0;
  int               dir_kind = -1;  // -1 = random instruction class
  int               dir_val  = -1;  // -1 = random condition flag

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outv_t act_out();
    return {state, write_pc, write_ir, write_a, write_b, write_c,
            write_nzcv, write_reg, illegal, alu_op, b_imm};
  endfunction

  function automatic bit is_cmp(input logic [31:0] ir);
    int op;
    op = int'(ir[24:21]);
    return (op >= 8 && op <= 11);
  endfunction

  function automatic outv_t exp_out(input int ph, input logic [31:0] ir);
    outv_t o;
    o    = '0;
    o.st = 3'(ph);
    case (ph)
      P_F: begin o.pc = 1'b1; o.wir = 1'b1; end
      P_D: begin o.a = 1'b1; o.b = 1'b1; o.ill = (ir[27:26] != 2'b00); end
      P_E: begin
        o.c    = 1'b1;
        o.op   = ir[24:21];
        o.bimm = ir[25];
        o.nzcv = ir[20] | is_cmp(ir);
      end
      P_W: o.wreg = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic [31:0] pick_ir(input int kind);
    logic [31:0] r;
    r = $urandom;
    case (kind)
      0: r = 32'hE0812003;            // ADD
      1: r = 32'hE3500000;            // CMP imm
      2: r = 32'hEA000000;            // branch class
      3: r[27:26] = 2'b00;            // any data-processing op
      default: ;                      // anything at all
    endcase
    return r;
  endfunction

  // One clock of stimulus; queues the outputs expected during this cycle.
  task automatic cycle(input bit rst_mid, input int run_pct);
    sb_t e;
    int  ph;
    int  k;
    @(posedge clk);
    #1;
    rst = 1'b0;
    if (start_next) begin
      k     = (dir_kind >= 0) ? dir_kind : int'($urandom_range(4));
      m_ir  = pick_ir(k);
      m_val = (dir_val >= 0) ? dir_val[0] : ($urandom_range(3) != 0);
      plan.delete();
      plan.push_back(P_F);
      if (m_val) begin
        plan.push_back(P_D);
        if (m_ir[27:26] == 2'b00) begin
          plan.push_back(P_E);
          if (!is_cmp(m_ir)) plan.push_back(P_W);
        end
      end
      idx        = 0;
      m_busy     = 1'b1;
      start_next = 1'b0;
    end else if (!m_busy) begin
      m_ir  = $urandom;               // IDLE must ignore IR entirely
      m_val = 1'($urandom_range(1));
    end
    IR         = m_ir;
    W_IR_valid = m_val;
    run        = (int'($urandom_range(99)) < run_pct);
    ph         = m_busy ? plan[idx] : P_I;
    e.o        = exp_out(ph, m_ir);
    e.cyc      = PERF ? m_cyc : '0;
    e.ins      = PERF ? m_ins : '0;
    if (rst_mid) begin
      #1 rst = 1'b1;
      #1;
      chk("async_reset_out", 64'(act_out()), 64'h0);
      chk("async_reset_cnt", {cycle_cnt, instr_cnt}, 64'h0);
      e          = '0;
      m_busy     = 1'b0;
      start_next = 1'b0;
      m_cyc      = '0;
      m_ins      = '0;
      sbq.push_back(e);
      return;
    end
    sbq.push_back(e);
    if (m_busy) begin
      m_cyc = m_cyc + 1'b1;
      if (idx == plan.size() - 1) begin
        if (ph == P_E || ph == P_W) m_ins = m_ins + 1'b1;
        m_busy     = 1'b0;
        start_next = run;
      end else begin
        idx++;
      end
    end else begin
      start_next = run;
    end
  endtask

  // Monitor: every falling edge is one presented output cycle.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("outputs", 64'(act_out()), 64'(e.o));
        chk("counters", {cycle_cnt, instr_cnt}, {e.cyc, e.ins});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("reset_out", 64'(act_out()), 64'h0);
    chk("reset_cnt", {cycle_cnt, instr_cnt}, 64'h0);

    // ADD, then CMP, then branch class, all with the condition passing.
    dir_val = 1; dir_kind = 0;
    repeat (5) cycle(1'b0, 100);      // IDLE + F D E W
    dir_kind = 1;
    repeat (3) cycle(1'b0, 100);      // F D E
    dir_kind = 2;
    repeat (2) cycle(1'b0, 100);      // F D(illegal)
    dir_val = 0;
    repeat (3) cycle(1'b0, 100);      // three skipped fetches

    // run dropped during DECODE of an ADD: completes, then parks.
    dir_val = 1; dir_kind = 0;
    cycle(1'b0, 100);                 // F
    cycle(1'b0, 0);                   // D
    cycle(1'b0, 0);                   // E
    cycle(1'b0, 0);                   // W -> IDLE
    repeat (3) cycle(1'b0, 0);

    // Reset in the middle of EXEC, then stay parked with run=0.
    cycle(1'b0, 100);                 // IDLE -> F
    cycle(1'b0, 100);                 // F
    cycle(1'b0, 100);                 // D
    cycle(1'b1, 100);                 // E, reset asserted mid-cycle
    repeat (3) cycle(1'b0, 0);

    // Random traffic with occasional resets.
    dir_kind = -1; dir_val = -1;
    repeat (600) cycle($urandom_range(99) == 0, 85);

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", 64'(sbq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
